// File: rtl/booth_mul_arbiter.sv
// booth_mul_arbiter: round-robin front end that shares one Booth multiplier
// among NREQ clients. It captures the winner's operands, pulses mul_start,
// waits for mul_done (bounded by TMO cycles) and returns the product.
`timescale 1ns/1ps
module booth_mul_arbiter #(
  parameter int N    = 8,
  parameter int NREQ = 4,
  parameter int TMO  = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*N-1:0] req_m,
  input  logic [NREQ*N-1:0] req_q,
  output logic [NREQ-1:0]   grant,
  output logic [NREQ-1:0]   rsp_valid,
  output logic [2*N-1:0]    rsp_data,
  output logic              rsp_err,
  output logic              busy,
  output logic              mul_start,
  output logic [N-1:0]      mul_m,
  output logic [N-1:0]      mul_q,
  input  logic              mul_done,
  input  logic [2*N-1:0]    mul_data
);

  localparam int IW = $clog2(NREQ);
  localparam int CW = $clog2(TMO);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   ptr_q;
  logic [IW-1:0]   cur_q;
  logic [IW-1:0]   sel;
  logic [IW-1:0]   ptr_next;
  logic [CW-1:0]   cnt_q;
  logic [NREQ-1:0] cur_oh;
  logic            done_ok;
  logic            tmo_hit;

  // First set request bit at or above p, wrapping modulo NREQ.
  function automatic logic [IW-1:0] rr_pick(input logic [NREQ-1:0] r,
                                            input logic [IW-1:0]   p);
    logic [IW-1:0] pick;
    logic [IW-1:0] jj;
    logic          found;
    int            j;
    pick  = p;
    found = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      j = int'(p) + i;
      if (j >= NREQ) j = j - NREQ;
      jj = IW'(j);
      if (!found && r[jj]) begin
        pick  = jj;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  assign sel      = rr_pick(req, ptr_q);
  assign cur_oh   = NREQ'(1) << cur_q;
  assign ptr_next = (cur_q == IW'(NREQ - 1)) ? '0 : cur_q + IW'(1);

  // A done level seen in the first WAIT cycle may be left over from the
  // previous operation, so it is only trusted once the counter has moved.
  assign done_ok  = mul_done && (cnt_q != '0);
  assign tmo_hit  = (cnt_q == CW'(TMO - 1));

  // Next-state and Moore-decoded control outputs.
  always_comb begin
    state_d   = state_q;
    grant     = '0;
    rsp_valid = '0;
    mul_start = 1'b0;
    busy      = (state_q != IDLE);
    case (state_q)
      IDLE:  if (|req) state_d = ISSUE;
      ISSUE: begin
        grant     = cur_oh;
        mul_start = 1'b1;
        state_d   = WAIT;
      end
      WAIT:  if (done_ok || tmo_hit) state_d = RESP;
      RESP:  begin
        rsp_valid = cur_oh;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, arbitration pointer, operand capture, timeout counter and result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      cur_q    <= '0;
      cnt_q    <= '0;
      mul_m    <= '0;
      mul_q    <= '0;
      rsp_data <= '0;
      rsp_err  <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (|req) begin
            cur_q <= sel;
            mul_m <= req_m[int'(sel)*N +: N];
            mul_q <= req_q[int'(sel)*N +: N];
          end
        end
        ISSUE: cnt_q <= '0;
        WAIT: begin
          cnt_q <= cnt_q + CW'(1);
          // Done takes priority over a coincident timeout.
          if (done_ok) begin
            rsp_data <= mul_data;
            rsp_err  <= 1'b0;
          end else if (tmo_hit) begin
            rsp_data <= '0;
            rsp_err  <= 1'b1;
          end
        end
        RESP: ptr_q <= ptr_next;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_booth_mul_arbiter.sv
// Directed testbench for booth_mul_arbiter with a behavioural multiplier
// driven from the test tasks.
`timescale 1ns/1ps
module tb_booth_mul_arbiter;

  localparam int N    = 8;
  localparam int NREQ = 4;
  localparam int TMO  = 20;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [31:0] req_m, req_q;
  logic [3:0]  grant, rsp_valid;
  logic [15:0] rsp_data;
  logic        rsp_err, busy, mul_start;
  logic [7:0]  mul_m, mul_q;
  logic        mul_done;
  logic [15:0] mul_data;

  int errors = 0;
  int checks = 0;

  logic [3:0]  g, rv;
  logic [15:0] rd;
  logic        re;
  int          n;

  logic [3:0]  fair_order [6] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
  logic [15:0] fair_prod  [6] = '{16'd5, 16'd10, 16'd15, 16'd20, 16'd5, 16'd10};

  booth_mul_arbiter #(.N(N), .NREQ(NREQ), .TMO(TMO)) dut (
    .clk(clk), .rst(rst), .req(req), .req_m(req_m), .req_q(req_q),
    .grant(grant), .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .busy(busy), .mul_start(mul_start), .mul_m(mul_m), .mul_q(mul_q),
    .mul_done(mul_done), .mul_data(mul_data)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1);
  end

  task automatic tick(input int cnt);
    repeat (cnt) @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1; req = '0; mul_done = 1'b0; mul_data = '0;
    tick(1);
    rst = 1'b0;
    tick(1);
  endtask

  // Wait (bounded) for a grant pulse; g stays 0 if none arrives.
  task automatic wait_grant(output logic [3:0] gv);
    gv = '0;
    for (int i = 0; i < 16; i++) begin
      tick(1);
      if (grant != '0) begin
        gv = grant;
        break;
      end
    end
  endtask

  // Multiplier model: after lat cycles raise done with the signed product of
  // the operands presented by the arbiter, then capture the response.
  task automatic finish_op(input int lat, output logic [3:0] rvo,
                           output logic [15:0] rdo, output logic reo);
    logic signed [15:0] a, b;
    tick(lat);
    a = {{8{mul_m[7]}}, mul_m};
    b = {{8{mul_q[7]}}, mul_q};
    mul_data = a * b;
    mul_done = 1'b1;
    tick(1);
    rvo = rsp_valid; rdo = rsp_data; reo = rsp_err;
    mul_done = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; req = '0; req_m = '0; req_q = '0; mul_done = 1'b0; mul_data = '0;
    tick(2);
    checks++; if (grant !== 4'b0) begin errors++; $display("FAIL reset_grant: got %b want 0000", grant); end
    checks++; if (rsp_valid !== 4'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b want 0000", rsp_valid); end
    checks++; if (rsp_data !== 16'h0) begin errors++; $display("FAIL reset_rsp_data: got %h want 0000", rsp_data); end
    checks++; if (rsp_err !== 1'b0) begin errors++; $display("FAIL reset_rsp_err: got %b want 0", rsp_err); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (mul_start !== 1'b0) begin errors++; $display("FAIL reset_mul_start: got %b want 0", mul_start); end
    checks++; if (mul_m !== 8'h0 || mul_q !== 8'h0) begin errors++; $display("FAIL reset_operands: got %h/%h want 00/00", mul_m, mul_q); end
    rst = 1'b0;
    tick(1);
  endtask

  task automatic test_single();
    do_reset();
    req = 4'b0001; req_m = 32'hAABBCC07; req_q = 32'h11223306;
    wait_grant(g);
    checks++; if (g !== 4'b0001) begin errors++; $display("FAIL single_grant: got %b want 0001", g); end
    checks++; if (mul_start !== 1'b1) begin errors++; $display("FAIL single_mul_start: got %b want 1", mul_start); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy: got %b want 1", busy); end
    checks++; if (mul_m !== 8'd7 || mul_q !== 8'd6) begin errors++; $display("FAIL single_operands: got %h/%h want 07/06", mul_m, mul_q); end
    req = '0;
    req_m = 32'hFFFFFFFF; req_q = 32'hFFFFFFFF;
    tick(1);
    checks++; if (grant !== 4'b0 || mul_start !== 1'b0) begin errors++; $display("FAIL single_pulse_width: got grant=%b start=%b want 0000/0", grant, mul_start); end
    checks++; if (mul_m !== 8'd7) begin errors++; $display("FAIL single_operand_hold: got %h want 07", mul_m); end
    finish_op(2, rv, rd, re);
    checks++; if (rv !== 4'b0001) begin errors++; $display("FAIL single_rsp_valid: got %b want 0001", rv); end
    checks++; if (rd !== 16'd42) begin errors++; $display("FAIL single_rsp_data: got %h want 002a", rd); end
    checks++; if (re !== 1'b0) begin errors++; $display("FAIL single_rsp_err: got %b want 0", re); end
    tick(1);
    checks++; if (rsp_valid !== 4'b0 || busy !== 1'b0) begin errors++; $display("FAIL single_idle_after: got valid=%b busy=%b want 0000/0", rsp_valid, busy); end
  endtask

  task automatic test_signed();
    do_reset();
    req = 4'b0100; req_m = 32'h11FD2233; req_q = 32'h44056677;
    wait_grant(g);
    checks++; if (g !== 4'b0100) begin errors++; $display("FAIL signed_grant1: got %b want 0100", g); end
    req = '0;
    finish_op(3, rv, rd, re);
    checks++; if (rv !== 4'b0100) begin errors++; $display("FAIL signed_valid1: got %b want 0100", rv); end
    checks++; if (rd !== 16'hFFF1) begin errors++; $display("FAIL signed_neg3x5: got %h want fff1", rd); end
    req = 4'b0100; req_m = 32'h11802233; req_q = 32'h44806677;
    wait_grant(g);
    checks++; if (g !== 4'b0100) begin errors++; $display("FAIL signed_grant2: got %b want 0100", g); end
    req = '0;
    finish_op(3, rv, rd, re);
    checks++; if (rd !== 16'h4000) begin errors++; $display("FAIL signed_min_x_min: got %h want 4000", rd); end
  endtask

  task automatic test_fairness();
    do_reset();
    req = 4'b1111; req_m = 32'h04030201; req_q = 32'h05050505;
    for (int k = 0; k < 6; k++) begin
      wait_grant(g);
      checks++; if (g !== fair_order[k]) begin errors++; $display("FAIL fair_grant_%0d: got %b want %b", k, g, fair_order[k]); end
      req = req & ~g;
      finish_op(3, rv, rd, re);
      checks++; if (rv !== fair_order[k] || rd !== fair_prod[k]) begin errors++; $display("FAIL fair_rsp_%0d: got %b/%h want %b/%h", k, rv, rd, fair_order[k], fair_prod[k]); end
      req = req | g;
    end
    req = '0;
    tick(2);
  endtask

  task automatic test_rotation();
    do_reset();
    req = 4'b0010; req_m = 32'h00000200; req_q = 32'h00000300;
    wait_grant(g);
    checks++; if (g !== 4'b0010) begin errors++; $display("FAIL rot_first: got %b want 0010", g); end
    req = '0;
    finish_op(3, rv, rd, re);
    req = 4'b0011;
    wait_grant(g);
    checks++; if (g !== 4'b0001) begin errors++; $display("FAIL rot_wrap: got %b want 0001", g); end
    req = 4'b0010;
    finish_op(3, rv, rd, re);
    wait_grant(g);
    checks++; if (g !== 4'b0010) begin errors++; $display("FAIL rot_second: got %b want 0010", g); end
    req = '0;
    finish_op(3, rv, rd, re);
  endtask

  task automatic test_timeout();
    do_reset();
    req = 4'b0001; req_m = 32'h00000007; req_q = 32'h00000006;
    wait_grant(g);
    req = '0;
    finish_op(3, rv, rd, re);
    checks++; if (rd !== 16'd42) begin errors++; $display("FAIL tmo_pre_product: got %h want 002a", rd); end
    req = 4'b0001; req_m = 32'h00000003; req_q = 32'h00000003;
    wait_grant(g);
    checks++; if (g !== 4'b0001) begin errors++; $display("FAIL tmo_grant: got %b want 0001", g); end
    req = '0;
    n = 0;
    for (int i = 1; i <= TMO + 8; i++) begin
      tick(1);
      if (rsp_valid != '0) begin
        n = i;
        break;
      end
    end
    checks++; if (n != TMO + 1) begin errors++; $display("FAIL tmo_latency: got %0d want %0d", n, TMO + 1); end
    checks++; if (rsp_valid !== 4'b0001) begin errors++; $display("FAIL tmo_valid: got %b want 0001", rsp_valid); end
    checks++; if (rsp_err !== 1'b1) begin errors++; $display("FAIL tmo_err: got %b want 1", rsp_err); end
    checks++; if (rsp_data !== 16'h0) begin errors++; $display("FAIL tmo_data: got %h want 0000", rsp_data); end
    tick(1);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL tmo_busy_drop: got %b want 0", busy); end
  endtask

  task automatic test_tie();
    logic signed [15:0] a, b;
    do_reset();
    req = 4'b0010; req_m = 32'h00000900; req_q = 32'h00000B00;
    wait_grant(g);
    req = '0;
    tick(TMO);
    checks++; if (rsp_valid !== 4'b0) begin errors++; $display("FAIL tie_early_rsp: got %b want 0000", rsp_valid); end
    a = {{8{mul_m[7]}}, mul_m};
    b = {{8{mul_q[7]}}, mul_q};
    mul_data = a * b;
    mul_done = 1'b1;
    tick(1);
    mul_done = 1'b0;
    checks++; if (rsp_valid !== 4'b0010) begin errors++; $display("FAIL tie_valid: got %b want 0010", rsp_valid); end
    checks++; if (rsp_err !== 1'b0 || rsp_data !== 16'h0063) begin errors++; $display("FAIL tie_done_wins: got err=%b data=%h want 0/0063", rsp_err, rsp_data); end
  endtask

  task automatic test_stale_done();
    do_reset();
    mul_done = 1'b1; mul_data = 16'hDEAD;
    req = 4'b0001; req_m = 32'h00000003; req_q = 32'h00000004;
    wait_grant(g);
    req = '0;
    tick(2);
    checks++; if (rsp_valid !== 4'b0 || busy !== 1'b1) begin errors++; $display("FAIL stale_done_accepted: got valid=%b busy=%b want 0000/1", rsp_valid, busy); end
    mul_done = 1'b0;
    finish_op(1, rv, rd, re);
    checks++; if (rv !== 4'b0001 || rd !== 16'h000C) begin errors++; $display("FAIL stale_real_rsp: got %b/%h want 0001/000c", rv, rd); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    req = 4'b0001; req_m = 32'h00000007; req_q = 32'h00000006;
    wait_grant(g);
    req = '0;
    finish_op(3, rv, rd, re);
    req = 4'b0010; req_m = 32'h00000500; req_q = 32'h00000500;
    wait_grant(g);
    req = '0;
    tick(2);
    rst = 1'b1;
    #1;
    checks++; if (busy !== 1'b0 || grant !== 4'b0 || mul_start !== 1'b0) begin errors++; $display("FAIL midrst_ctrl: got busy=%b grant=%b start=%b want 0/0000/0", busy, grant, mul_start); end
    checks++; if (rsp_data !== 16'h0 || rsp_err !== 1'b0) begin errors++; $display("FAIL midrst_rsp: got data=%h err=%b want 0000/0", rsp_data, rsp_err); end
    checks++; if (mul_m !== 8'h0 || mul_q !== 8'h0) begin errors++; $display("FAIL midrst_operands: got %h/%h want 00/00", mul_m, mul_q); end
    mul_data = 16'd25; mul_done = 1'b1;
    tick(2);
    checks++; if (rsp_valid !== 4'b0) begin errors++; $display("FAIL midrst_no_rsp: got %b want 0000", rsp_valid); end
    mul_done = 1'b0;
    rst = 1'b0;
    tick(1);
    checks++; if (rsp_valid !== 4'b0 || busy !== 1'b0) begin errors++; $display("FAIL midrst_release_idle: got valid=%b busy=%b want 0000/0", rsp_valid, busy); end
    req = 4'b0100; req_m = 32'h00090000; req_q = 32'h00020000;
    wait_grant(g);
    checks++; if (g !== 4'b0100) begin errors++; $display("FAIL midrst_next_grant: got %b want 0100", g); end
    req = '0;
    finish_op(3, rv, rd, re);
    checks++; if (rv !== 4'b0100 || rd !== 16'd18) begin errors++; $display("FAIL midrst_next_rsp: got %b/%h want 0100/0012", rv, rd); end
  endtask

  initial begin
    rst = 1'b1; req = '0; req_m = '0; req_q = '0; mul_done = 1'b0; mul_data = '0;
    test_reset();
    test_single();
    test_signed();
    test_fairness();
    test_rotation();
    test_timeout();
    test_tie();
    test_stale_done();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
